// File: rtl/weight_fifo.sv
// Per-lane weight staging buffer feeding the systolic array weight inputs.
// Each lane is an independent shift register with occupancy tracking and head recirculation.
module weight_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_INPUTS = 16,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [FIFO_INPUTS-1:0]            en,
   input  logic                              weight_write,
   input  logic                              recirculate,
   input  logic [FIFO_INPUTS*DATA_WIDTH-1:0] din,
   output logic [FIFO_INPUTS*DATA_WIDTH-1:0] dout,
   output logic [FIFO_INPUTS-1:0]            lane_full,
   output logic                              all_full,
   output logic                              any_empty,
   output logic                              overflow
);

   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

   logic [FIFO_INPUTS-1:0] push_s;
   logic [FIFO_INPUTS-1:0] full_s;
   logic [FIFO_INPUTS-1:0] empty_s;
   logic [FIFO_INPUTS-1:0] ovf_hit_s;
   logic                   overflow_r;

   assign push_s = en & {FIFO_INPUTS{weight_write}};

   for (genvar i = 0; i < FIFO_INPUTS; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] stage_r [FIFO_DEPTH];
      logic [CNT_WIDTH-1:0]  count_r;

      // Lane shift register and saturating occupancy counter
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
               stage_r[k] <= '0;
            end
            count_r <= '0;
         end else if (push_s[i]) begin
            stage_r[0] <= recirculate ? stage_r[FIFO_DEPTH-1]
                                      : din[i*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 1; k < FIFO_DEPTH; k++) begin
               stage_r[k] <= stage_r[k-1];
            end
            // Recirculation rotates in place, so occupancy only grows on fresh loads
            if (!recirculate && (count_r != FULL_CNT)) begin
               count_r <= count_r + ONE_CNT;
            end else begin
               count_r <= count_r;
            end
         end else begin
            count_r <= count_r;
         end
      end

      assign dout[i*DATA_WIDTH +: DATA_WIDTH] = stage_r[FIFO_DEPTH-1];
      assign full_s[i]    = (count_r == FULL_CNT);
      assign empty_s[i]   = (count_r == '0);
      assign ovf_hit_s[i] = push_s[i] & ~recirculate & full_s[i];
   end

   // Sticky overflow: a fresh push into a full lane discards that lane's head word
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (|ovf_hit_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign lane_full = full_s;
   assign all_full  = &full_s;
   assign any_empty = |empty_s;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_weight_fifo.sv
// Directed self-checking bench for weight_fifo: load, stagger, recirculate, overflow, reset.
module tb_weight_fifo;

   localparam int W = 8;
   localparam int N = 16;
   localparam int D = 16;

   logic             clk;
   logic             reset;
   logic [N-1:0]     en;
   logic             weight_write;
   logic             recirculate;
   logic [N*W-1:0]   din;
   logic [N*W-1:0]   dout;
   logic [N-1:0]     lane_full;
   logic             all_full;
   logic             any_empty;
   logic             overflow;

   int total;
   int bad;

   weight_fifo #(.DATA_WIDTH(W), .FIFO_INPUTS(N), .FIFO_DEPTH(D)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .weight_write(weight_write),
      .recirculate(recirculate),
      .din(din),
      .dout(dout),
      .lane_full(lane_full),
      .all_full(all_full),
      .any_empty(any_empty),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word p of a full load: lane i carries 16*p + i
   function automatic logic [N*W-1:0] load_word(input int p);
      logic [N*W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         v[i*W +: W] = 8'((16 * p + i) & 255);
      end
      return v;
   endfunction

   task automatic drive(input logic ww, input logic [N-1:0] e, input logic rc,
                        input logic [N*W-1:0] d, input logic rst);
      @(negedge clk);
      weight_write = ww;
      en           = e;
      recirculate  = rc;
      din          = d;
      reset        = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 16'h0000, 1'b0, '0, 1'b1);
      drive(1'b0, 16'h0000, 1'b0, '0, 1'b1);
      for (int c = 0; c < 5; c++) drive(1'b0, 16'h0000, 1'b0, load_word(3), 1'b0);
      total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h expected 0", dout); end
      total++; if (any_empty !== 1'b1) begin bad++; $display("FAIL reset_any_empty: got %b expected 1", any_empty); end
      total++; if (all_full !== 1'b0) begin bad++; $display("FAIL reset_all_full: got %b expected 0", all_full); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      total++; if (lane_full !== 16'h0000) begin bad++; $display("FAIL reset_lane_full: got %h expected 0000", lane_full); end
   endtask

   task automatic test_full_load();
      for (int p = 0; p < D; p++) begin
         drive(1'b1, 16'hFFFF, 1'b0, load_word(p), 1'b0);
         if (p == D - 2) begin
            total++; if (dout !== '0) begin bad++; $display("FAIL load15_dout: got %h expected 0", dout); end
            total++; if (all_full !== 1'b0) begin bad++; $display("FAIL load15_all_full: got %b expected 0", all_full); end
            total++; if (any_empty !== 1'b0) begin bad++; $display("FAIL load15_any_empty: got %b expected 0", any_empty); end
         end
      end
      total++; if (all_full !== 1'b1) begin bad++; $display("FAIL load_all_full: got %b expected 1", all_full); end
      total++; if (lane_full !== 16'hFFFF) begin bad++; $display("FAIL load_lane_full: got %h expected ffff", lane_full); end
      total++; if (dout !== load_word(0)) begin bad++; $display("FAIL load_dout: got %h expected %h", dout, load_word(0)); end
      drive(1'b0, 16'hFFFF, 1'b0, load_word(7), 1'b0);
      drive(1'b1, 16'h0000, 1'b0, load_word(8), 1'b0);
      drive(1'b0, 16'h0000, 1'b1, load_word(9), 1'b0);
      total++; if (dout !== load_word(0)) begin bad++; $display("FAIL hold_dout: got %h expected %h", dout, load_word(0)); end
      total++; if (all_full !== 1'b1) begin bad++; $display("FAIL hold_all_full: got %b expected 1", all_full); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL load_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_recirculate();
      for (int r = 1; r <= D; r++) begin
         drive(1'b1, 16'hFFFF, 1'b1, load_word(50 + r), 1'b0);
         total++;
         if (dout !== load_word(r % D)) begin
            bad++; $display("FAIL recirc_dout_%0d: got %h expected %h", r, dout, load_word(r % D));
         end
      end
      total++; if (lane_full !== 16'hFFFF) begin bad++; $display("FAIL recirc_lane_full: got %h expected ffff", lane_full); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL recirc_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_overflow();
      logic [N*W-1:0] exp;
      exp = load_word(0);
      exp[3*W +: W] = 8'd19;
      drive(1'b1, 16'h0008, 1'b0, {N{8'hAB}}, 1'b0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      total++; if (dout !== exp) begin bad++; $display("FAIL ovf_dout: got %h expected %h", dout, exp); end
      total++; if (lane_full !== 16'hFFFF) begin bad++; $display("FAIL ovf_lane_full: got %h expected ffff", lane_full); end
      for (int c = 0; c < 3; c++) drive(1'b0, 16'h0000, 1'b0, '0, 1'b0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      total++; if (dout !== exp) begin bad++; $display("FAIL ovf_idle_dout: got %h expected %h", dout, exp); end
   endtask

   task automatic test_staggered();
      logic [N-1:0]   e;
      logic [N-1:0]   exp_full;
      logic [N*W-1:0] exp_head;
      drive(1'b0, 16'h0000, 1'b0, '0, 1'b1);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stag_reset_ovf: got %b expected 0", overflow); end
      for (int c = 0; c < N + D - 1; c++) begin
         e = '0;
         exp_full = '0;
         for (int i = 0; i < N; i++) begin
            e[i]        = (c >= i) && (c < i + D);
            exp_full[i] = (c >= i + D - 1);
         end
         drive(1'b1, e, 1'b0, {N{8'((c + 64) & 255)}}, 1'b0);
         total++;
         if (lane_full !== exp_full) begin
            bad++; $display("FAIL stag_lane_full_c%0d: got %h expected %h", c, lane_full, exp_full);
         end
         total++;
         if (all_full !== (c == N + D - 2)) begin
            bad++; $display("FAIL stag_all_full_c%0d: got %b expected %b", c, all_full, (c == N + D - 2));
         end
         total++;
         if (any_empty !== (c < N - 1)) begin
            bad++; $display("FAIL stag_any_empty_c%0d: got %b expected %b", c, any_empty, (c < N - 1));
         end
      end
      exp_head = '0;
      for (int i = 0; i < N; i++) exp_head[i*W +: W] = 8'(i + 64);
      total++; if (dout !== exp_head) begin bad++; $display("FAIL stag_dout: got %h expected %h", dout, exp_head); end
   endtask

   task automatic test_midload_reset();
      drive(1'b0, 16'h0000, 1'b0, '0, 1'b1);
      for (int p = 0; p < 7; p++) drive(1'b1, 16'hFFFF, 1'b0, load_word(p + 3), 1'b0);
      drive(1'b1, 16'hFFFF, 1'b0, load_word(10), 1'b1);
      total++; if (dout !== '0) begin bad++; $display("FAIL mid_dout: got %h expected 0", dout); end
      total++; if (lane_full !== 16'h0000) begin bad++; $display("FAIL mid_lane_full: got %h expected 0000", lane_full); end
      total++; if (any_empty !== 1'b1) begin bad++; $display("FAIL mid_any_empty: got %b expected 1", any_empty); end
      test_full_load();
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      en           = '0;
      weight_write = 1'b0;
      recirculate  = 1'b0;
      din          = '0;
      test_reset();
      test_full_load();
      test_recirculate();
      test_overflow();
      test_staggered();
      test_midload_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/weight_fifo.md
Name: weight_fifo

Overview:
Per-lane weight staging buffer that sits directly downstream of the FIFO load controller and feeds the systolic array's weight inputs. It contains FIFO_INPUTS independent shift-register lanes, each FIFO_DEPTH words deep. A lane advances only on cycles where the controller's weight_write is high and that lane's enable bit is set. It tracks per-lane occupancy, reports full lanes, flags overflow, and supports recirculating loaded weights for reuse without reloading from memory.

Parameters:
DATA_WIDTH, 8, bits per weight word
FIFO_INPUTS, 16, number of lanes; equals the load controller's fifo_width
FIFO_DEPTH, 16, words per lane
CNT_WIDTH, $clog2(FIFO_DEPTH)+1, localparam; per-lane occupancy counter width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
en  input  FIFO_INPUTS  per-lane shift enable (controller fifo_en); bit i drives lane i
weight_write  input  1  push qualifier from controller; a lane shifts only when weight_write && en[i]
recirculate  input  1  when 1, a shifting lane takes its own head word into stage 0 instead of din
din  input  FIFO_INPUTS*DATA_WIDTH  lane i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
dout  output  FIFO_INPUTS*DATA_WIDTH  lane i head word (stage FIFO_DEPTH-1), same packing as din
lane_full  output  FIFO_INPUTS  bit i = lane i occupancy equals FIFO_DEPTH
all_full  output  1  AND of lane_full
any_empty  output  1  1 if any lane occupancy is 0
overflow  output  1  sticky; set when a non-recirculate push hits a full lane

Behaviour:
- Reset (reset=1 at posedge): all stages 0, all counters 0, overflow 0. Takes priority over every other input in the same cycle. Outputs after reset: dout=0, lane_full=0, all_full=0, any_empty=1, overflow=0.
- Lane i shift (push_i = weight_write & en[i]):
  - stage[0] <= recirculate ? stage[FIFO_DEPTH-1] : din lane i
  - stage[k] <= stage[k-1] for k=1..FIFO_DEPTH-1
- Lanes with push_i=0 hold every stage and their counter. Lanes are fully independent, so different lanes may shift in the same cycle or on different cycles (staggered enables).
- dout is registered state (head stage), with no combinational path from din. The first word pushed into an empty lane appears on dout after exactly FIFO_DEPTH pushes on that lane. Idle cycles between pushes do not count.
- Occupancy counter, lane i:
  - push_i && !recirculate: count+1, saturating at FIFO_DEPTH.
  - push_i && recirculate: count unchanged. The rotation is lossless only when the lane is full.
  - no push: unchanged.
- Overflow: push_i && !recirculate && count_i==FIFO_DEPTH sets overflow. The shift still occurs (the head word is discarded) and the count stays at FIFO_DEPTH. overflow clears only on reset.
- Recirculate on a non-full lane is legal. Zero stages rotate into the data path and this is not flagged.
- Flags are combinational from the registered counters:
  - lane_full[i] = (count_i == FIFO_DEPTH)
  - all_full = &lane_full
  - any_empty = |(count_i == 0)
- weight_write=1 with en=0: no state change. en≠0 with weight_write=0: no state change.
- Reset mid-load: contents and counters are discarded and the next push starts from an empty lane.
- No X propagation: all registers have defined reset values.

Test Plan:
- Reset then idle 5 cycles with en=0 → dout=0, any_empty=1, all_full=0, overflow=0.
- Full load, all lanes (FIFO_DEPTH=16): weight_write=1, en=16'hFFFF, lane i din = 16*push_idx+i for 16 cycles → all_full=1 on the cycle after the 16th push; dout lane i = i (first word pushed); no change while weight_write=0.
- Staggered load: en bit i rises at cycle i and stays on for 16 cycles (diagonal pattern) → lane_full[i] asserts at cycle i+16; lane 0 full while lane 15 shows count 1; all_full rises only after lane 15 completes.
- Recirculate: after full load, 16 pushes with recirculate=1 → dout steps through words 0..15 and returns to word 0; counts stay 16; overflow stays 0.
- Overflow: one further push with recirculate=0 on a full lane 3 (en=16'h0008), din=8'hAB → overflow=1 and lane 3 head advances to word 1; other lanes unchanged; overflow holds through idle cycles until reset.
- Mid-load reset: assert reset after 7 pushes (with weight_write=1 in that same cycle) → all counters 0 and dout=0 next cycle; a fresh 16-push load then behaves exactly as the full-load scenario.
